// File: rtl/instr_decode_queue.sv
// Instruction queue with a registered decode stage: FIFO of {ir, pc} feeding a decoded output bundle.
// Optional branch-target adder is enabled by defining INSTR_DECODE_BTARGET_EN.
`timescale 1ns/1ps
module instr_decode_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16,
    parameter int PC_W   = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_ir,
    input  logic [PC_W-1:0]   in_pc,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        opcode,
    output logic [1:0]        op,
    output logic [1:0]        alu_op,
    output logic [1:0]        shift,
    output logic [2:0]        rn,
    output logic [2:0]        rd,
    output logic [2:0]        rm,
    output logic [2:0]        cond,
    output logic [DATA_W-1:0] sximm5,
    output logic [DATA_W-1:0] sximm8,
    output logic [PC_W-1:0]   out_pc,
    output logic [PC_W-1:0]   btarget,
    output logic [CNT_W-1:0]  count
);
    logic [15+PC_W:0]  r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_out_valid;
    logic [2:0]        r_opcode;
    logic [1:0]        r_op;
    logic [1:0]        r_shift;
    logic [2:0]        r_rn;
    logic [2:0]        r_rd;
    logic [2:0]        r_rm;
    logic [DATA_W-1:0] r_sximm5;
    logic [DATA_W-1:0] r_sximm8;
    logic [PC_W-1:0]   r_out_pc;

    logic              w_push;
    logic              w_load;
    logic [15:0]       w_head_ir;
    logic [PC_W-1:0]   w_head_pc;
    logic [DATA_W-1:0] w_sximm5;
    logic [DATA_W-1:0] w_sximm8;

    // in_ready is a pure function of occupancy so fetch never sees a path from out_ready.
    assign in_ready  = (r_count < CNT_W'(DEPTH));
    assign w_push    = in_valid && in_ready && !flush;
    assign w_load    = (r_count != '0) && (!r_out_valid || out_ready) && !flush;
    assign w_head_ir = r_mem[r_rd_ptr][15+PC_W:PC_W];
    assign w_head_pc = r_mem[r_rd_ptr][PC_W-1:0];
    assign w_sximm5  = {{(DATA_W-5){w_head_ir[4]}}, w_head_ir[4:0]};
    assign w_sximm8  = {{(DATA_W-8){w_head_ir[7]}}, w_head_ir[7:0]};

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_ir, in_pc};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_opcode    <= '0;
            r_op        <= '0;
            r_shift     <= '0;
            r_rn        <= '0;
            r_rd        <= '0;
            r_rm        <= '0;
            r_sximm5    <= '0;
            r_sximm8    <= '0;
            r_out_pc    <= '0;
        end else if (flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_push && !w_load) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_load && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
            if (w_load) begin
                r_rd_ptr    <= r_rd_ptr + AW'(1);
                r_out_valid <= 1'b1;
                r_opcode    <= w_head_ir[15:13];
                r_op        <= w_head_ir[12:11];
                r_shift     <= w_head_ir[4:3];
                r_rn        <= w_head_ir[10:8];
                r_rd        <= w_head_ir[7:5];
                r_rm        <= w_head_ir[2:0];
                r_sximm5    <= w_sximm5;
                r_sximm8    <= w_sximm8;
                r_out_pc    <= w_head_pc;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef INSTR_DECODE_BTARGET_EN
    logic [PC_W-1:0] r_btarget;
    logic [PC_W-1:0] w_btarget;

    assign w_btarget = w_head_pc + PC_W'(1) + w_sximm8[PC_W-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_btarget <= '0;
        end else if (w_load) begin
            r_btarget <= w_btarget;
        end
    end
    assign btarget = r_btarget;
`else
    assign btarget = '0;
`endif

    assign count     = r_count;
    assign out_valid = r_out_valid;
    assign opcode    = r_opcode;
    assign op        = r_op;
    assign alu_op    = r_op;
    assign shift     = r_shift;
    assign rn        = r_rn;
    assign rd        = r_rd;
    assign rm        = r_rm;
    assign cond      = r_rn;
    assign sximm5    = r_sximm5;
    assign sximm8    = r_sximm8;
    assign out_pc    = r_out_pc;
endmodule

// File: tb/tb_instr_decode_queue.sv
// Scoreboard bench for instr_decode_queue: accepted pushes queue expected bundles, a negedge monitor
// pops and compares on every output handshake. Honours INSTR_DECODE_BTARGET_EN for btarget.
`timescale 1ns/1ps
module tb_instr_decode_queue;
    localparam int DEPTH  = 4;
    localparam int DATA_W = 16;
    localparam int PC_W   = 8;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       in_ir;
    logic [PC_W-1:0]   in_pc;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [2:0]        opcode;
    logic [1:0]        op;
    logic [1:0]        alu_op;
    logic [1:0]        shift;
    logic [2:0]        rn;
    logic [2:0]        rd;
    logic [2:0]        rm;
    logic [2:0]        cond;
    logic [DATA_W-1:0] sximm5;
    logic [DATA_W-1:0] sximm8;
    logic [PC_W-1:0]   out_pc;
    logic [PC_W-1:0]   btarget;
    logic [CNT_W-1:0]  count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int opcode, op, shift, rn, rd, rm;
        int sx5, sx8, pc, bt;
    } exp_t;

    exp_t exp_q[$];

    instr_decode_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .PC_W(PC_W)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_ir(in_ir), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .opcode(opcode), .op(op), .alu_op(alu_op),
        .shift(shift), .rn(rn), .rd(rd), .rm(rm), .cond(cond), .sximm5(sximm5),
        .sximm8(sximm8), .out_pc(out_pc), .btarget(btarget), .count(count)
    );

    always #5 clk = ~clk;

    // Reference decode from field positions and two's-complement arithmetic.
    function automatic exp_t model(input int ir, input int pc);
        exp_t e;
        int v5, v8;
        e.opcode = ir / 8192;
        e.op     = (ir / 2048) % 4;
        e.rn     = (ir / 256) % 8;
        e.rd     = (ir / 32) % 8;
        e.shift  = (ir / 8) % 4;
        e.rm     = ir % 8;
        v5 = ir % 32;
        if (v5 >= 16) v5 -= 32;
        v8 = ir % 256;
        if (v8 >= 128) v8 -= 256;
        e.sx5 = v5 & ((1 << DATA_W) - 1);
        e.sx8 = v8 & ((1 << DATA_W) - 1);
        e.pc  = pc;
`ifdef INSTR_DECODE_BTARGET_EN
        e.bt  = (pc + 1 + v8) & ((1 << PC_W) - 1);
`else
        e.bt  = 0;
`endif
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: decisions for the upcoming edge are made at the negedge when inputs and outputs are stable.
    always @(negedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
        end else begin
            chk("occupancy", int'(count) + int'(out_valid), exp_q.size());
            chk("in_ready_rule", int'(in_ready), int'(count < CNT_W'(DEPTH)));
            if (flush) begin
                exp_q.delete();
            end else begin
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("scoreboard_underflow", 1, 0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("opcode", int'(opcode), e.opcode);
                        chk("op", int'(op), e.op);
                        chk("alu_op", int'(alu_op), e.op);
                        chk("shift", int'(shift), e.shift);
                        chk("rn", int'(rn), e.rn);
                        chk("rd", int'(rd), e.rd);
                        chk("rm", int'(rm), e.rm);
                        chk("cond", int'(cond), e.rn);
                        chk("sximm5", int'(sximm5), e.sx5);
                        chk("sximm8", int'(sximm8), e.sx8);
                        chk("out_pc", int'(out_pc), e.pc);
                        chk("btarget", int'(btarget), e.bt);
                        $display("out pc=0x%02h opcode=%0d rn=%0d rd=%0d rm=%0d sximm8=0x%04h", out_pc, opcode, rn, rd, rm, sximm8);
                    end
                end
                if (in_valid && in_ready) begin
                    exp_q.push_back(model(int'(in_ir), int'(in_pc)));
                    $display("in  ir=0x%04h pc=0x%02h", in_ir, in_pc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [15:0] ir, input logic [PC_W-1:0] pc);
        in_valid = 1'b1;
        in_ir    = ir;
        in_pc    = pc;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        int pushed;
        int cyc;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_ir     = '0;
        in_pc     = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        #12;
        chk("reset_count", int'(count), 0);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_in_ready", int'(in_ready), 1);
        chk("reset_sximm8", int'(sximm8), 0);
        reset_n = 1'b1;
        tick();

        // Basic decode with fixed words.
        out_ready = 1'b1;
        push_word(16'hD583, 8'h10);
        tick();
        chk("t1_out_valid", int'(out_valid), 1);
        chk("t1_opcode", int'(opcode), 6);
        chk("t1_rn", int'(rn), 5);
        chk("t1_sximm8", int'(sximm8), 'hFF83);
`ifdef INSTR_DECODE_BTARGET_EN
        chk("t1_btarget", int'(btarget), 'h94);
`else
        chk("t1_btarget", int'(btarget), 0);
`endif
        push_word(16'hA13F, 8'h11);
        tick();
        chk("t2_shift", int'(shift), 3);
        chk("t2_sximm5", int'(sximm5), 'hFFFF);
        chk("t2_sximm8", int'(sximm8), 'h003F);
        tick();
        chk("t2_drained", int'(out_valid), 0);

        // Fill: one word in the output register plus DEPTH in the FIFO.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_word(16'h1000 + 16'(i * 16'h0123), PC_W'(8'h20 + i));
        chk("full_count", int'(count), 4);
        chk("full_in_ready", int'(in_ready), 0);
        chk("full_out_valid", int'(out_valid), 1);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("drain_out_valid", int'(out_valid), 0);
        chk("drain_count", int'(count), 0);

        // Flush with count = 3, output valid and a concurrent push.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_word(16'h2222 + 16'(i), PC_W'(8'h40 + i));
        chk("preflush_count", int'(count), 3);
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_ir     = 16'hEEEE;
        in_pc     = 8'hEE;
        out_ready = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_count", int'(count), 0);
        chk("flush_out_valid", int'(out_valid), 0);
        tick();
        tick();
        chk("flush_no_ghost", int'(out_valid), 0);

        // Asynchronous reset between edges.
        out_ready = 1'b0;
        push_word(16'h5A5A, 8'h50);
        push_word(16'h6B6B, 8'h51);
        push_word(16'h7C7C, 8'h52);
        #3;
        reset_n = 1'b0;
        #1;
        chk("areset_count", int'(count), 0);
        chk("areset_out_valid", int'(out_valid), 0);
        chk("areset_opcode", int'(opcode), 0);
        chk("areset_sximm5", int'(sximm5), 0);
        chk("areset_out_pc", int'(out_pc), 0);
        chk("areset_btarget", int'(btarget), 0);
        chk("areset_in_ready", int'(in_ready), 1);
        @(negedge clk);
        #2;
        reset_n = 1'b1;
        tick();
        out_ready = 1'b1;
        push_word(16'hD583, 8'h10);
        tick();
        chk("post_reset_valid", int'(out_valid), 1);
        chk("post_reset_sximm8", int'(sximm8), 'hFF83);

        // Randomised stream with stalls to exercise pointer wrap.
        pushed = 0;
        cyc    = 0;
        while (pushed < 20 && cyc < 400) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_ir     = 16'($urandom);
            in_pc     = PC_W'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            if (in_valid && in_ready) pushed++;
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        chk("stream_pushed", pushed, 20);
        out_ready = 1'b1;
        cyc = 0;
        while ((out_valid || count != 0) && cyc < 50) begin
            tick();
            cyc++;
        end
        chk("stream_drain_timeout", int'(out_valid || count != 0), 0);
        tick();
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
